ex_stage: RTL and testbench

Execute stage of the pipelined RV32I core. It sits directly downstream of the ALU decoder and consumes its 3-bit `alu_cntrl` together with the ID/EX operands. It computes the ALU result and the branch decision, then registers the result into the EX/MEM pipeline register. A valid/ready handshake with the memory stage lets the stage stall, and a flush input lets it squash the incoming instruction.

---
 rtl/riscv_pkg.sv | 17 +
 rtl/alu.sv | 35 +++
 rtl/ex_stage.sv | 116 +++++++++++
 tb/tb_ex_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: default datapath width, ALU operation codes
// and forwarding-mux select codes used by the execute stage.
package riscv_pkg;

  localparam int DEF_XLEN = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/alu.sv
// Combinational RV32I ALU: add/sub/and/or/slt, modulo 2^XLEN.
// Unknown operation codes fall back to add. zero flags an all-zero result.
module alu
  import riscv_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_cntrl,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  logic signed [XLEN-1:0] a_s;
  logic signed [XLEN-1:0] b_s;

  assign a_s = a;
  assign b_s = b;

  // Operation select; slt is a signed compare zero-extended to XLEN
  always_comb begin
    result = a + b;
    case (alu_cntrl)
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(XLEN-1){1'b0}}, (a_s < b_s)};
      default: result = a + b;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// RV32I execute stage: operand forwarding, ALU, branch decision and the
// EX/MEM pipeline register with a valid/ready handshake toward MEM.
// Optional feature macro: EX_FORWARD_EN builds the fwd_a_sel/fwd_b_sel
// operand muxes; without it operands come straight from the register file
// and the forwarding ports are present but ignored.
module ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [XLEN-1:0]   rs1_data,
  input  logic [XLEN-1:0]   rs2_data,
  input  logic [XLEN-1:0]   imm,
  input  logic [XLEN-1:0]   pc,
  input  logic              alu_src,
  input  logic [2:0]        alu_cntrl,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_write,
  input  logic              mem_write,
  input  logic              branch,
  input  logic [1:0]        result_src,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [XLEN-1:0]   wb_result,
  input  logic              flush,
  input  logic              mem_ready,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_alu_result,
  output logic [XLEN-1:0]   ex_write_data,
  output logic [REG_AW-1:0] ex_rd,
  output logic              ex_reg_write,
  output logic              ex_mem_write,
  output logic [1:0]        ex_result_src,
  output logic              pc_src,
  output logic [XLEN-1:0]   pc_target
);

  logic [XLEN-1:0] fwd_a_p0;
  logic [XLEN-1:0] fwd_b_p0;
  logic [XLEN-1:0] op_b_p0;
  logic [XLEN-1:0] alu_result_p0;
  logic            zero_p0;
  logic            take_p0;

`ifdef EX_FORWARD_EN
  // Operand A forwarding mux; the reserved code reads the register file
  always_comb begin
    case (fwd_a_sel)
      FWD_WB:  fwd_a_p0 = wb_result;
      FWD_MEM: fwd_a_p0 = mem_result;
      default: fwd_a_p0 = rs1_data;
    endcase
  end

  // Operand B / store-data forwarding mux
  always_comb begin
    case (fwd_b_sel)
      FWD_WB:  fwd_b_p0 = wb_result;
      FWD_MEM: fwd_b_p0 = mem_result;
      default: fwd_b_p0 = rs2_data;
    endcase
  end
`else
  logic unused_fwd;

  assign fwd_a_p0   = rs1_data;
  assign fwd_b_p0   = rs2_data;
  assign unused_fwd = ^{fwd_a_sel, fwd_b_sel, mem_result, wb_result};
`endif

  assign op_b_p0 = alu_src ? imm : fwd_b_p0;

  alu #(.XLEN(XLEN)) u_alu (
    .a         (fwd_a_p0),
    .b         (op_b_p0),
    .alu_cntrl (alu_cntrl),
    .result    (alu_result_p0),
    .zero      (zero_p0)
  );

  // A stall only ever comes from MEM refusing a valid EX/MEM entry
  assign id_ready  = !ex_valid || mem_ready;
  assign take_p0   = id_valid && !flush;
  assign pc_src    = branch && zero_p0 && take_p0 && id_ready;
  assign pc_target = pc + imm;

  // ---- EX/MEM boundary ----
  // Load on id_ready, hold on stall; write enables are qualified so an
  // invalid entry can never commit a register or memory write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid      <= 1'b0;
      ex_alu_result <= '0;
      ex_write_data <= '0;
      ex_rd         <= '0;
      ex_reg_write  <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_result_src <= '0;
    end else if (id_ready) begin
      ex_valid      <= take_p0;
      ex_alu_result <= alu_result_p0;
      ex_write_data <= fwd_b_p0;
      ex_rd         <= rd;
      ex_reg_write  <= reg_write && take_p0;
      ex_mem_write  <= mem_write && take_p0;
      ex_result_src <= result_src;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: table of ALU vectors plus hand-written
// sequences for branch, stall, flush and reset-mid-stall behaviour.
module tb_ex_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic              id_ready;
  logic [XLEN-1:0]   rs1_data, rs2_data, imm, pc;
  logic              alu_src;
  logic [2:0]        alu_cntrl;
  logic [REG_AW-1:0] rd;
  logic              reg_write, mem_write, branch;
  logic [1:0]        result_src, fwd_a_sel, fwd_b_sel;
  logic [XLEN-1:0]   mem_result, wb_result;
  logic              flush, mem_ready;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_alu_result, ex_write_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write, ex_mem_write;
  logic [1:0]        ex_result_src;
  logic              pc_src;
  logic [XLEN-1:0]   pc_target;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ready(id_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
    .alu_src(alu_src), .alu_cntrl(alu_cntrl), .rd(rd),
    .reg_write(reg_write), .mem_write(mem_write), .branch(branch),
    .result_src(result_src), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_result(mem_result), .wb_result(wb_result), .flush(flush),
    .mem_ready(mem_ready), .ex_valid(ex_valid),
    .ex_alu_result(ex_alu_result), .ex_write_data(ex_write_data),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_write(ex_mem_write),
    .ex_result_src(ex_result_src), .pc_src(pc_src), .pc_target(pc_target)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic        src;
    logic [1:0]  fa;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] im;
    logic [31:0] mres;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    rst_n = 1'b0; id_valid = 1'b0; rs1_data = '0; rs2_data = '0; imm = '0;
    pc = '0; alu_src = 1'b0; alu_cntrl = 3'b000; rd = '0; reg_write = 1'b0;
    mem_write = 1'b0; branch = 1'b0; result_src = 2'b00; fwd_a_sel = 2'b00;
    fwd_b_sel = 2'b00; mem_result = '0; wb_result = '0; flush = 1'b0;
    mem_ready = 1'b1;

    tbl[0] = '{3'b001, 1'b0, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFE};
    tbl[1] = '{3'b000, 1'b0, 2'b00, 32'd5, 32'd7, 32'd0, 32'd0, 32'd12};
    tbl[2] = '{3'b010, 1'b0, 2'b00, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'h00F0};
    tbl[3] = '{3'b011, 1'b0, 2'b00, 32'hF0F0, 32'h0FF0, 32'd0, 32'd0, 32'hFFF0};
    tbl[4] = '{3'b101, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd1};
    tbl[5] = '{3'b101, 1'b0, 2'b00, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};
    tbl[6] = '{3'b111, 1'b0, 2'b00, 32'd3, 32'd4, 32'd0, 32'd0, 32'd7};
    tbl[7] = '{3'b000, 1'b1, 2'b00, 32'h10, 32'h99, 32'h20, 32'd0, 32'h30};
    tbl[8] = '{3'b000, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0};
`ifdef EX_FORWARD_EN
    tbl[9] = '{3'b000, 1'b1, 2'b10, 32'd1, 32'd0, 32'd4, 32'h40, 32'h44};
`else
    tbl[9] = '{3'b000, 1'b1, 2'b10, 32'd1, 32'd0, 32'd4, 32'h40, 32'd5};
`endif

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rst_id_ready", {31'd0, id_ready}, 32'd1);
    chk("rst_alu_result", ex_alu_result, 32'd0);
    chk("rst_reg_write", {31'd0, ex_reg_write}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Table-driven ALU vectors, one per cycle with MEM always ready
    for (int i = 0; i < 10; i++) begin
      id_valid = 1'b1; reg_write = 1'b1; mem_write = 1'b0;
      alu_cntrl = tbl[i].op; alu_src = tbl[i].src; fwd_a_sel = tbl[i].fa;
      rs1_data = tbl[i].a; rs2_data = tbl[i].b; imm = tbl[i].im;
      mem_result = tbl[i].mres; wb_result = 32'h77; rd = REG_AW'(i + 1);
      result_src = 2'(i);
      tick();
      chk($sformatf("vec%0d_result", i), ex_alu_result, tbl[i].exp);
      chk($sformatf("vec%0d_wdata", i), ex_write_data, tbl[i].b);
      chk($sformatf("vec%0d_rd", i), {27'd0, ex_rd}, i + 1);
      chk($sformatf("vec%0d_valid", i), {31'd0, ex_valid & ex_reg_write}, 32'd1);
      chk($sformatf("vec%0d_rsrc", i), {30'd0, ex_result_src}, i % 4);
    end
    fwd_a_sel = 2'b00;

    // Branch taken only in the accept cycle
    rs1_data = 32'h10; rs2_data = 32'h10; alu_cntrl = 3'b001; alu_src = 1'b0;
    branch = 1'b1; pc = 32'h100; imm = 32'h20; reg_write = 1'b0;
    #1;
    chk("br_pc_src", {31'd0, pc_src}, 32'd1);
    chk("br_pc_target", pc_target, 32'h120);
    tick();
    id_valid = 1'b0;
    #1;
    chk("br_pc_src_after", {31'd0, pc_src}, 32'd0);
    branch = 1'b0;
    tick();

    // Stall: load A, then hold MEM off for 3 cycles while B (a taken branch) waits
    id_valid = 1'b1; rs1_data = 32'd1; rs2_data = 32'd2; alu_cntrl = 3'b000;
    rd = 5'd3; reg_write = 1'b1;
    tick();
    chk("st_load_a", ex_alu_result, 32'd3);
    mem_ready = 1'b0;
    rs1_data = 32'h10; rs2_data = 32'h10; alu_cntrl = 3'b001; branch = 1'b1; rd = 5'd9;
    #1;
    chk("st_id_ready", {31'd0, id_ready}, 32'd0);
    chk("st_pc_src", {31'd0, pc_src}, 32'd0);
    for (int c = 0; c < 3; c++) begin
      flush = (c == 1);
      tick();
      chk($sformatf("st%0d_result", c), ex_alu_result, 32'd3);
      chk($sformatf("st%0d_rd", c), {27'd0, ex_rd}, 32'd3);
      chk($sformatf("st%0d_valid", c), {31'd0, ex_valid}, 32'd1);
      chk($sformatf("st%0d_pc_src", c), {31'd0, pc_src}, 32'd0);
    end
    flush = 1'b0; mem_ready = 1'b1;
    #1;
    chk("st_release_pc_src", {31'd0, pc_src}, 32'd1);
    tick();
    chk("st_b_result", ex_alu_result, 32'd0);
    chk("st_b_rd", {27'd0, ex_rd}, 32'd9);
    branch = 1'b0;

    // Flush: squash an offered instruction that would write a register
    id_valid = 1'b1; reg_write = 1'b1; mem_write = 1'b1; flush = 1'b1;
    branch = 1'b1; rs1_data = 32'd4; rs2_data = 32'd4; alu_cntrl = 3'b001;
    #1;
    chk("fl_pc_src", {31'd0, pc_src}, 32'd0);
    tick();
    chk("fl_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_reg_write", {31'd0, ex_reg_write}, 32'd0);
    chk("fl_mem_write", {31'd0, ex_mem_write}, 32'd0);
    flush = 1'b0; branch = 1'b0; mem_write = 1'b0;

    // Reset mid-stall discards the held instruction asynchronously
    rs1_data = 32'd6; rs2_data = 32'd1; alu_cntrl = 3'b000; rd = 5'd7;
    tick();
    chk("rs_loaded", ex_alu_result, 32'd7);
    mem_ready = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_result", ex_alu_result, 32'd0);
    chk("rs_rd", {27'd0, ex_rd}, 32'd0);
    chk("rs_id_ready", {31'd0, id_ready}, 32'd1);
    tick();
    rst_n = 1'b1;
    id_valid = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
